// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared widths, load-op encodings and the EXE->MEM bus layout
//                for the MEM pipeline stage.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 75;
   localparam int MS_TO_WS_BUS_WD = 70;
   localparam int MS_TO_DS_BUS_WD = 39;

   // load_op encodings; 5..7 fall back to a full-word load
   typedef enum logic [2:0] {
      LD_W  = 3'd0,
      LD_B  = 3'd1,
      LD_BU = 3'd2,
      LD_H  = 3'd3,
      LD_HU = 3'd4
   } load_op_e;

   // Field layout of the EXE->MEM bus, MSB first
   typedef struct packed {
      logic        mem_req;
      logic [2:0]  load_op;
      logic        gr_we;
      logic        res_from_mem;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : EXE->MEM, MEM->WB, MEM->ID bypass and data-SRAM response
//                signals of the MEM stage. The stage uses the slave view;
//                the surrounding pipeline uses the master view.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                       es_to_ms_valid;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
   logic                       ms_allowin;
   logic                       ws_allowin;
   logic                       ms_to_ws_valid;
   logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
   logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;
   logic                       data_sram_data_ok;
   logic [31:0]                data_sram_rdata;

   modport slave (
      input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
             data_sram_data_ok, data_sram_rdata,
      output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
   );

   modport master (
      output es_to_ms_valid, es_to_ms_bus, ws_allowin,
             data_sram_data_ok, data_sram_rdata,
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_bus
   );

endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_align
//  Description : Selects the addressed byte/half of a loaded word and sign-
//                or zero-extends it according to load_op. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  load_op,
   output logic [31:0] result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection, then extension per load type
   always_comb begin
      w_byte = 8'h00;
      w_half = 16'h0000;
      result = word;
      case (addr)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
      w_half = addr[1] ? word[31:16] : word[15:0];
      case (load_op)
         LD_B:    result = {{24{w_byte[7]}}, w_byte};
         LD_BU:   result = {24'h000000, w_byte};
         LD_H:    result = {{16{w_half[15]}}, w_half};
         LD_HU:   result = {16'h0000, w_half};
         default: result = word;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage. Holds one instruction from EXE, waits for
//                the data-SRAM response of memory requests, keeps an early
//                response in a one-entry buffer while WB stalls, and aligns
//                load data before handing the result to WB and decode bypass.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   mem_stage_if.slave  bus
);

   logic        ms_valid_q,  ms_valid_d;
   es_to_ms_t   ms_bus_q,    ms_bus_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_data_q,  buf_data_d;

   logic        w_wait_resp;
   logic        w_ready_go;
   logic        w_allowin;
   logic        w_to_ws_valid;
   logic        w_leave;
   logic [31:0] w_word;
   logic [31:0] w_load_data;
   logic [31:0] w_final_result;

   // Handshake: a memory instruction stalls until its response arrives or is buffered
   always_comb begin
      w_wait_resp   = ms_valid_q & ms_bus_q.mem_req & ~buf_valid_q;
      w_ready_go    = ~w_wait_resp | bus.data_sram_data_ok;
      w_allowin     = ~ms_valid_q | (w_ready_go & bus.ws_allowin);
      w_to_ws_valid = ms_valid_q & w_ready_go;
      w_leave       = w_to_ws_valid & bus.ws_allowin;
   end

   // Next state: entry, drain, and capture of a response WB cannot take yet
   always_comb begin
      ms_valid_d  = ms_valid_q;
      ms_bus_d    = ms_bus_q;
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      if (bus.es_to_ms_valid & w_allowin) begin
         ms_valid_d = 1'b1;
         ms_bus_d   = es_to_ms_t'(bus.es_to_ms_bus);
      end else if (w_leave) begin
         ms_valid_d = 1'b0;
      end
      // Leaving wins over a set, so a departing instruction never leaves data behind
      if (w_leave) begin
         buf_valid_d = 1'b0;
      end else if (bus.data_sram_data_ok & w_wait_resp) begin
         buf_valid_d = 1'b1;
         buf_data_d  = bus.data_sram_rdata;
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid_q  <= 1'b0;
         ms_bus_q    <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= 32'h0;
      end else begin
         ms_valid_q  <= ms_valid_d;
         ms_bus_q    <= ms_bus_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign w_word = buf_valid_q ? buf_data_q : bus.data_sram_rdata;

   mem_load_align u_align (
      .word    (w_word),
      .addr    (ms_bus_q.alu_result[1:0]),
      .load_op (ms_bus_q.load_op),
      .result  (w_load_data)
   );

   assign w_final_result = ms_bus_q.res_from_mem ? w_load_data : ms_bus_q.alu_result;

   assign bus.ms_allowin     = w_allowin;
   assign bus.ms_to_ws_valid = w_to_ws_valid;
   assign bus.ms_to_ws_bus   = {ms_bus_q.gr_we, ms_bus_q.dest, w_final_result, ms_bus_q.pc};
   assign bus.ms_to_ds_bus   = {ms_valid_q & ms_bus_q.res_from_mem & ~w_ready_go,
                                ms_valid_q & ms_bus_q.gr_we,
                                ms_bus_q.dest,
                                w_final_result};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_pass   = 0;

   mem_stage_if u_if ();

   mem_stage u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (u_if)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [74:0] mk(input logic mem_req, input logic [2:0] op,
                                      input logic we, input logic rfm, input logic [4:0] dest,
                                      input logic [31:0] alu, input logic [31:0] pc);
      return {mem_req, op, we, rfm, dest, alu, pc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single cycle; returns just after the entry edge
   task automatic enter(input logic [74:0] b);
      u_if.es_to_ms_valid = 1'b1;
      u_if.es_to_ms_bus   = b;
      step();
      u_if.es_to_ms_valid = 1'b0;
   endtask

   // Load whose response arrives in the entry cycle
   task automatic imm_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
      enter(mk(1'b1, op, 1'b1, 1'b1, 5'd7, addr, 32'h1c00_0100));
      #1;
      check({tag, " pend"}, 70'(u_if.ms_to_ds_bus[38]), 70'(1'b1));
      u_if.data_sram_data_ok = 1'b1;
      u_if.data_sram_rdata   = rdata;
      #1;
      check({tag, " valid"},  70'(u_if.ms_to_ws_valid), 70'(1'b1));
      check({tag, " result"}, 70'(u_if.ms_to_ws_bus[63:32]), 70'(exp));
      step();
      u_if.data_sram_data_ok = 1'b0;
      u_if.data_sram_rdata   = 32'h0;
      #1;
      check({tag, " drained"}, 70'(u_if.ms_to_ws_valid), 70'(1'b0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      resetn                 = 1'b0;
      u_if.es_to_ms_valid    = 1'b0;
      u_if.es_to_ms_bus      = '0;
      u_if.ws_allowin        = 1'b1;
      u_if.data_sram_data_ok = 1'b0;
      u_if.data_sram_rdata   = 32'h0;
      step();
      step();
      check("rst allowin", 70'(u_if.ms_allowin), 70'(1'b1));
      check("rst valid",   70'(u_if.ms_to_ws_valid), 70'(1'b0));
      check("rst pend",    70'(u_if.ms_to_ds_bus[38]), 70'(1'b0));
      check("rst fwd_we",  70'(u_if.ms_to_ds_bus[37]), 70'(1'b0));
      resetn = 1'b1;
      step();

      // Non-memory ALU instruction
      u_if.es_to_ms_valid = 1'b1;
      u_if.es_to_ms_bus   = mk(1'b0, 3'd0, 1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'h1c00_0000);
      #1;
      check("alu allowin", 70'(u_if.ms_allowin), 70'(1'b1));
      step();
      u_if.es_to_ms_valid = 1'b0;
      check("alu valid",  70'(u_if.ms_to_ws_valid), 70'(1'b1));
      check("alu ws_bus", 70'(u_if.ms_to_ws_bus),
            70'({1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000}));
      check("alu ds_bus", 70'(u_if.ms_to_ds_bus), 70'({1'b0, 1'b1, 5'd5, 32'h0000_1234}));
      step();
      check("alu drained", 70'(u_if.ms_to_ws_valid), 70'(1'b0));

      // Immediate-response loads with alignment/extension
      imm_load("ld_b",  LD_B,  32'h1000_0003, 32'h80FF_00AA, 32'hFFFF_FF80);
      imm_load("ld_bu", LD_BU, 32'h1000_0003, 32'h80FF_00AA, 32'h0000_0080);
      imm_load("ld_h",  LD_H,  32'h1000_0002, 32'h80FF_00AA, 32'hFFFF_80FF);
      imm_load("ld_hu", LD_HU, 32'h1000_0001, 32'h80FF_00AA, 32'h0000_00AA);
      imm_load("ld_op7", 3'd7, 32'h1000_0002, 32'h80FF_00AA, 32'h80FF_00AA);

      // Delayed response with a back-to-back follower
      enter(mk(1'b1, LD_W, 1'b1, 1'b1, 5'd9, 32'h2000_0000, 32'h1c00_0200));
      for (int i = 0; i < 3; i++) begin
         check("dly allowin", 70'(u_if.ms_allowin), 70'(1'b0));
         check("dly pend",    70'(u_if.ms_to_ds_bus[38]), 70'(1'b1));
         step();
      end
      u_if.data_sram_data_ok = 1'b1;
      u_if.data_sram_rdata   = 32'hDEAD_BEEF;
      u_if.es_to_ms_valid    = 1'b1;
      u_if.es_to_ms_bus      = mk(1'b0, 3'd0, 1'b1, 1'b0, 5'd6, 32'h0000_0055, 32'h1c00_0204);
      #1;
      check("dly valid",   70'(u_if.ms_to_ws_valid), 70'(1'b1));
      check("dly result",  70'(u_if.ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
      check("dly allowin", 70'(u_if.ms_allowin), 70'(1'b1));
      step();
      u_if.data_sram_data_ok = 1'b0;
      u_if.es_to_ms_valid    = 1'b0;
      #1;
      check("b2b valid",  70'(u_if.ms_to_ws_valid), 70'(1'b1));
      check("b2b result", 70'(u_if.ms_to_ws_bus[68:32]), 70'({5'd6, 32'h0000_0055}));
      step();
      check("b2b drained", 70'(u_if.ms_to_ws_valid), 70'(1'b0));

      // Store: waits like a load but never reports load_pending
      enter(mk(1'b1, LD_W, 1'b0, 1'b0, 5'd0, 32'h3000_0010, 32'h1c00_0300));
      check("st allowin", 70'(u_if.ms_allowin), 70'(1'b0));
      check("st pend",    70'(u_if.ms_to_ds_bus[38]), 70'(1'b0));
      check("st valid0",  70'(u_if.ms_to_ws_valid), 70'(1'b0));
      u_if.data_sram_data_ok = 1'b1;
      #1;
      check("st valid1", 70'(u_if.ms_to_ws_valid), 70'(1'b1));
      check("st result", 70'(u_if.ms_to_ws_bus[63:32]), 70'(32'h3000_0010));
      step();
      u_if.data_sram_data_ok = 1'b0;

      // WB stall: response must be buffered
      u_if.ws_allowin = 1'b0;
      enter(mk(1'b1, LD_W, 1'b1, 1'b1, 5'd3, 32'h4000_0000, 32'h1c00_0400));
      u_if.data_sram_data_ok = 1'b1;
      u_if.data_sram_rdata   = 32'hCAFE_F00D;
      #1;
      check("stall valid",   70'(u_if.ms_to_ws_valid), 70'(1'b1));
      check("stall allowin", 70'(u_if.ms_allowin), 70'(1'b0));
      step();
      u_if.data_sram_data_ok = 1'b0;
      u_if.data_sram_rdata   = 32'h1111_1111;
      #1;
      check("stall buf_valid", 70'(u_dut.buf_valid_q), 70'(1'b1));
      check("stall result",    70'(u_if.ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
      check("stall pend",      70'(u_if.ms_to_ds_bus[38]), 70'(1'b0));
      step();
      step();
      step();
      u_if.ws_allowin = 1'b1;
      #1;
      check("release valid",   70'(u_if.ms_to_ws_valid), 70'(1'b1));
      check("release result",  70'(u_if.ms_to_ws_bus[63:32]), 70'(32'hCAFE_F00D));
      check("release allowin", 70'(u_if.ms_allowin), 70'(1'b1));
      step();
      check("release buf_clr", 70'(u_dut.buf_valid_q), 70'(1'b0));
      check("release drained", 70'(u_if.ms_to_ws_valid), 70'(1'b0));

      // Reset while waiting, with a response landing in the reset cycle
      enter(mk(1'b1, LD_W, 1'b1, 1'b1, 5'd4, 32'h5000_0000, 32'h1c00_0500));
      step();
      resetn                 = 1'b0;
      u_if.data_sram_data_ok = 1'b1;
      u_if.data_sram_rdata   = 32'h5555_5555;
      step();
      resetn                 = 1'b1;
      u_if.data_sram_data_ok = 1'b0;
      #1;
      check("mrst allowin", 70'(u_if.ms_allowin), 70'(1'b1));
      check("mrst valid",   70'(u_if.ms_to_ws_valid), 70'(1'b0));
      check("mrst pend",    70'(u_if.ms_to_ds_bus[38]), 70'(1'b0));
      check("mrst buf",     70'(u_dut.buf_valid_q), 70'(1'b0));
      u_if.data_sram_data_ok = 1'b1;
      u_if.data_sram_rdata   = 32'h6666_6666;
      #1;
      check("late ok valid", 70'(u_if.ms_to_ws_valid), 70'(1'b0));
      step();
      u_if.data_sram_data_ok = 1'b0;
      check("late ok buf",   70'(u_dut.buf_valid_q), 70'(1'b0));
      check("late ok valid2", 70'(u_if.ms_to_ws_valid), 70'(1'b0));

      // Stray response with the stage empty
      u_if.data_sram_data_ok = 1'b1;
      #1;
      check("stray valid", 70'(u_if.ms_to_ws_valid), 70'(1'b0));
      step();
      u_if.data_sram_data_ok = 1'b0;
      check("stray buf",     70'(u_dut.buf_valid_q), 70'(1'b0));
      check("stray allowin", 70'(u_if.ms_allowin), 70'(1'b1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
